// File: rtl/ca_pkg.sv
// Shared types and constants for the 8x8 cellular-automaton board scheduler.
package ca_pkg;

    localparam int unsigned ROW_W     = 8;
    localparam int unsigned NROWS     = 8;
    localparam int unsigned ROW_IDX_W = 3;
    localparam int unsigned BOARD_W   = ROW_W * NROWS;

    localparam logic GRANT_GEN  = 1'b0;
    localparam logic GRANT_HOST = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_DONE  = 3'd2,
        ST_HWR   = 3'd3,
        ST_CLEAR = 3'd4,
        ST_SEED  = 3'd5
    } ca_state_e;

    // One board write-port transaction
    typedef struct packed {
        logic                 en;
        logic [ROW_IDX_W-1:0] row;
        logic [ROW_W-1:0]     val;
    } ca_wr_t;

    // Extract row r from the flattened board (row r = bits 8r+7:8r)
    function automatic logic [ROW_W-1:0] board_row(input logic [BOARD_W-1:0]   b,
                                                   input logic [ROW_IDX_W-1:0] r);
        return b[r*ROW_W +: ROW_W];
    endfunction

endpackage

// File: rtl/ca_gen_scheduler_if.sv
// Host row-loader handshake and board write-port bundles for the CA scheduler.
interface ca_host_if;
    import ca_pkg::*;

    logic                 host_req;
    logic [ROW_IDX_W-1:0] host_row;
    logic [ROW_W-1:0]     host_data;
    logic                 host_ack;

    modport master (output host_req, host_row, host_data, input  host_ack);
    modport slave  (input  host_req, host_row, host_data, output host_ack);
endinterface

interface ca_board_if;
    import ca_pkg::*;

    logic                 load_r;
    logic [ROW_IDX_W-1:0] row_select;
    logic [ROW_W-1:0]     r_val;
    logic [BOARD_W-1:0]   board_in;

    modport master (output load_r, row_select, r_val, input  board_in);
    modport slave  (input  load_r, row_select, r_val, output board_in);
endinterface

// File: rtl/ca_next_row.sv
// Combinational elementary-CA step: one 8-bit row plus a Wolfram rule gives the next row.
module ca_next_row
    import ca_pkg::*;
#(
    parameter bit WRAP = 1'b1
) (
    input  logic [ROW_W-1:0] row,
    input  logic [ROW_W-1:0] rule,
    output logic [ROW_W-1:0] nxt
);

    // Row padded with its out-of-row neighbours: ext[i+1] = row[i]
    logic [ROW_W+1:0] ext;
    logic             edge_hi;
    logic             edge_lo;

    assign edge_hi = WRAP ? row[0]       : 1'b0;
    assign edge_lo = WRAP ? row[ROW_W-1] : 1'b0;
    assign ext     = {edge_hi, row, edge_lo};

    // Neighbourhood {left, centre, right} indexes the rule byte
    always_comb begin
        nxt = '0;
        for (int i = 0; i < ROW_W; i++) begin
            nxt[i] = rule[ext[i +: 3]];
        end
    end

endmodule

// File: rtl/ca_gen_scheduler.sv
// Generation sequencer and single write-port arbiter for the 8x8 CA board.
module ca_gen_scheduler
    import ca_pkg::*;
#(
    parameter int unsigned GEN_W = 16,
    parameter bit          WRAP  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic                 run,
    input  logic                 step,
    ca_host_if.slave             host,
    input  logic                 rule_ld,
    input  logic [ROW_W-1:0]     rule_in,
    input  logic                 clr,
    input  logic [ROW_W-1:0]     seed_val,
    ca_board_if.master           board,
    output logic [ROW_W-1:0]     cur_rule,
    output logic [ROW_IDX_W-1:0] head,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 busy
);

    ca_state_e            state, state_nxt;
    ca_wr_t               wr, wr_nxt;
    logic                 ack, ack_nxt;
    logic [ROW_W-1:0]     rule_nxt;
    logic [ROW_IDX_W-1:0] head_nxt;
    logic [GEN_W-1:0]     gen_count_nxt;
    logic                 busy_nxt;
    logic                 gen_pend, gen_pend_nxt;
    logic                 clr_pend, clr_pend_nxt;
    logic                 last_grant, last_grant_nxt;
    logic [ROW_IDX_W-1:0] clr_row, clr_row_nxt;

    logic                 gen_req_c;
    logic                 clr_req_c;
    logic [ROW_W-1:0]     cur_row_c;
    logic [ROW_W-1:0]     calc_row_c;

    assign board.load_r     = wr.en;
    assign board.row_select = wr.row;
    assign board.r_val      = wr.val;
    assign host.host_ack    = ack;

    // Requests arriving this cycle count alongside the latched ones
    assign gen_req_c = gen_pend | step | (tick & run);
    assign clr_req_c = clr_pend | clr;
    assign cur_row_c = board_row(board.board_in, head);

    ca_next_row #(.WRAP(WRAP)) u_next_row (
        .row  (cur_row_c),
        .rule (cur_rule),
        .nxt  (calc_row_c)
    );

    // Next-state, write-port and bookkeeping decode
    always_comb begin
        state_nxt      = state;
        wr_nxt         = wr;
        wr_nxt.en      = 1'b0;
        ack_nxt        = 1'b0;
        rule_nxt       = rule_ld ? rule_in : cur_rule;
        head_nxt       = head;
        gen_count_nxt  = gen_count;
        gen_pend_nxt   = gen_req_c;
        clr_pend_nxt   = clr_req_c;
        last_grant_nxt = last_grant;
        clr_row_nxt    = clr_row;

        unique case (state)
            ST_IDLE: begin
                if (clr_req_c) begin
                    state_nxt    = ST_CLEAR;
                    clr_pend_nxt = 1'b0;
                    clr_row_nxt  = '0;
                    wr_nxt.en    = 1'b1;
                    wr_nxt.row   = '0;
                    wr_nxt.val   = '0;
                end else if (gen_req_c && (!host.host_req || last_grant == GRANT_HOST)) begin
                    state_nxt      = ST_CALC;
                    gen_pend_nxt   = 1'b0;
                    last_grant_nxt = GRANT_GEN;
                end else if (host.host_req) begin
                    state_nxt      = ST_HWR;
                    wr_nxt.en      = 1'b1;
                    wr_nxt.row     = host.host_row;
                    wr_nxt.val     = host.host_data;
                    ack_nxt        = 1'b1;
                    last_grant_nxt = GRANT_HOST;
                end
            end

            ST_CALC: begin
                state_nxt  = ST_DONE;
                wr_nxt.en  = 1'b1;
                wr_nxt.row = head + ROW_IDX_W'(1);
                wr_nxt.val = calc_row_c;
            end

            ST_DONE: begin
                state_nxt     = ST_IDLE;
                head_nxt      = head + ROW_IDX_W'(1);
                gen_count_nxt = gen_count + GEN_W'(1);
            end

            ST_HWR: begin
                state_nxt = ST_IDLE;
            end

            // clr_row is the row whose zero write is on the port this cycle
            ST_CLEAR: begin
                wr_nxt.en = 1'b1;
                if (clr_row == ROW_IDX_W'(NROWS - 1)) begin
                    state_nxt  = ST_SEED;
                    wr_nxt.row = '0;
                    wr_nxt.val = seed_val;
                end else begin
                    clr_row_nxt = clr_row + ROW_IDX_W'(1);
                    wr_nxt.row  = clr_row + ROW_IDX_W'(1);
                    wr_nxt.val  = '0;
                end
            end

            ST_SEED: begin
                state_nxt     = ST_IDLE;
                head_nxt      = '0;
                gen_count_nxt = '0;
                gen_pend_nxt  = 1'b0;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            wr         <= '0;
            ack        <= 1'b0;
            cur_rule   <= '0;
            head       <= '0;
            gen_count  <= '0;
            busy       <= 1'b0;
            gen_pend   <= 1'b0;
            clr_pend   <= 1'b0;
            last_grant <= GRANT_GEN;
            clr_row    <= '0;
        end else begin
            state      <= state_nxt;
            wr         <= wr_nxt;
            ack        <= ack_nxt;
            cur_rule   <= rule_nxt;
            head       <= head_nxt;
            gen_count  <= gen_count_nxt;
            busy       <= busy_nxt;
            gen_pend   <= gen_pend_nxt;
            clr_pend   <= clr_pend_nxt;
            last_grant <= last_grant_nxt;
            clr_row    <= clr_row_nxt;
        end
    end

endmodule

// File: tb/tb_ca_gen_scheduler.sv
// Randomised and directed bench for ca_gen_scheduler against an operation-level reference model.
module tb_ca_gen_scheduler;

    localparam int unsigned GEN_W = 16;
    localparam int OP_NONE = 0;
    localparam int OP_GEN  = 1;
    localparam int OP_HOST = 2;
    localparam int OP_CLR  = 3;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       tick     = 1'b0;
    logic       run      = 1'b0;
    logic       step     = 1'b0;
    logic       rule_ld  = 1'b0;
    logic       clr      = 1'b0;
    logic [7:0] rule_in  = 8'h00;
    logic [7:0] seed_val = 8'h00;
    logic       host_req = 1'b0;
    logic [2:0] host_row = 3'd0;
    logic [7:0] host_data = 8'h00;

    logic [7:0]       cur_rule, cur_rule_nw;
    logic [2:0]       head, head_nw;
    logic [GEN_W-1:0] gen_count, gen_count_nw;
    logic             busy, busy_nw;

    ca_host_if  hif();
    ca_host_if  hif_nw();
    ca_board_if bif();
    ca_board_if bif_nw();

    assign hif.host_req     = host_req;
    assign hif.host_row     = host_row;
    assign hif.host_data    = host_data;
    assign hif_nw.host_req  = host_req;
    assign hif_nw.host_row  = host_row;
    assign hif_nw.host_data = host_data;

    // Board register arrays (bench-side storage, not reset by the DUT)
    logic [7:0] board    [8] = '{default: 8'h00};
    logic [7:0] board_nw [8] = '{default: 8'h00};

    assign bif.board_in    = {board[7], board[6], board[5], board[4],
                              board[3], board[2], board[1], board[0]};
    assign bif_nw.board_in = {board_nw[7], board_nw[6], board_nw[5], board_nw[4],
                              board_nw[3], board_nw[2], board_nw[1], board_nw[0]};

    always @(posedge clk) if (bif.load_r)    board[bif.row_select]       <= bif.r_val;
    always @(posedge clk) if (bif_nw.load_r) board_nw[bif_nw.row_select] <= bif_nw.r_val;

    always #5 clk = ~clk;

    ca_gen_scheduler #(.GEN_W(GEN_W), .WRAP(1'b1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick),
        .run       (run),
        .step      (step),
        .host      (hif),
        .rule_ld   (rule_ld),
        .rule_in   (rule_in),
        .clr       (clr),
        .seed_val  (seed_val),
        .board     (bif),
        .cur_rule  (cur_rule),
        .head      (head),
        .gen_count (gen_count),
        .busy      (busy)
    );

    ca_gen_scheduler #(.GEN_W(GEN_W), .WRAP(1'b0)) dut_nw (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick),
        .run       (run),
        .step      (step),
        .host      (hif_nw),
        .rule_ld   (rule_ld),
        .rule_in   (rule_in),
        .clr       (clr),
        .seed_val  (seed_val),
        .board     (bif_nw),
        .cur_rule  (cur_rule_nw),
        .head      (head_nw),
        .gen_count (gen_count_nw),
        .busy      (busy_nw)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: elementary CA rule applied bit by bit
    function automatic logic [7:0] ref_next(input logic [7:0] row, input logic [7:0] rule,
                                            input bit wrap);
        logic [7:0] res;
        int l, c, r;
        res = 8'h00;
        for (int i = 0; i < 8; i++) begin
            c = int'(row[i]);
            if (i == 7) l = wrap ? int'(row[0]) : 0;
            else        l = int'(row[i+1]);
            if (i == 0) r = wrap ? int'(row[7]) : 0;
            else        r = int'(row[i-1]);
            res[i] = rule[l*4 + c*2 + r];
        end
        return res;
    endfunction

    // Model: expected outputs for the current cycle, plus operation in flight
    logic             e_load, e_ack, e_busy;
    logic [2:0]       e_row, e_head;
    logic [7:0]       e_val, e_rule;
    logic [GEN_W-1:0] e_gen;
    bit               m_gen_pend, m_clr_pend, m_last_host;
    int               op, age;
    logic [7:0]       mboard [8] = '{default: 8'h00};

    task automatic model_reset();
        e_load = 1'b0; e_ack = 1'b0; e_busy = 1'b0;
        e_row = 3'd0; e_head = 3'd0; e_val = 8'h00; e_rule = 8'h00; e_gen = '0;
        m_gen_pend = 1'b0; m_clr_pend = 1'b0; m_last_host = 1'b0;
        op = OP_NONE; age = 0;
    endtask

    task automatic model_step();
        bit greq, creq, np_gen, np_clr;
        logic             n_load, n_ack;
        logic [2:0]       n_row, n_head;
        logic [7:0]       n_val, n_rule;
        logic [GEN_W-1:0] n_gen;
        greq   = m_gen_pend | step | (tick & run);
        creq   = m_clr_pend | clr;
        np_gen = greq;
        np_clr = creq;
        n_load = 1'b0; n_ack = 1'b0;
        n_row  = e_row; n_val = e_val; n_head = e_head; n_gen = e_gen;
        n_rule = rule_ld ? rule_in : e_rule;
        if (op == OP_NONE) begin
            age = 0;
            if (creq)                  op = OP_CLR;
            else if (greq && host_req) op = m_last_host ? OP_GEN : OP_HOST;
            else if (greq)             op = OP_GEN;
            else if (host_req)         op = OP_HOST;
            if (op == OP_CLR)  np_clr = 1'b0;
            if (op == OP_GEN)  begin np_gen = 1'b0; m_last_host = 1'b0; end
            if (op == OP_HOST) m_last_host = 1'b1;
        end else begin
            age++;
        end
        case (op)
            OP_GEN: begin
                if (age == 1) begin
                    n_load = 1'b1;
                    n_row  = e_head + 3'd1;
                    n_val  = ref_next(mboard[e_head], e_rule, 1'b1);
                end else if (age == 2) begin
                    n_head = e_head + 3'd1;
                    n_gen  = e_gen + GEN_W'(1);
                end
            end
            OP_HOST: begin
                if (age == 0) begin
                    n_load = 1'b1; n_ack = 1'b1; n_row = host_row; n_val = host_data;
                end
            end
            OP_CLR: begin
                if (age <= 7) begin
                    n_load = 1'b1; n_row = 3'(age); n_val = 8'h00;
                end else if (age == 8) begin
                    n_load = 1'b1; n_row = 3'd0; n_val = seed_val;
                end else begin
                    n_head = 3'd0; n_gen = '0; np_gen = 1'b0;
                end
            end
            default: ;
        endcase
        if ((op == OP_GEN && age == 2) || (op == OP_HOST && age == 1) || (op == OP_CLR && age == 9))
            op = OP_NONE;
        if (e_load) mboard[e_row] = e_val;
        m_gen_pend = np_gen;
        m_clr_pend = np_clr;
        e_load = n_load; e_ack = n_ack; e_row = n_row; e_val = n_val;
        e_head = n_head; e_gen = n_gen; e_rule = n_rule;
        e_busy = (op != OP_NONE);
    endtask

    task automatic check_outputs();
        chk("load_r",    32'(bif.load_r),  32'(e_load));
        chk("host_ack",  32'(hif.host_ack), 32'(e_ack));
        chk("head",      32'(head),        32'(e_head));
        chk("gen_count", 32'(gen_count),   32'(e_gen));
        chk("busy",      32'(busy),        32'(e_busy));
        chk("cur_rule",  32'(cur_rule),    32'(e_rule));
        chk("nw_load_r", 32'(bif_nw.load_r),  32'(e_load));
        chk("nw_ack",    32'(hif_nw.host_ack), 32'(e_ack));
        chk("nw_head",   32'(head_nw),      32'(e_head));
        chk("nw_gen",    32'(gen_count_nw), 32'(e_gen));
        chk("nw_busy",   32'(busy_nw),      32'(e_busy));
        chk("nw_rule",   32'(cur_rule_nw),  32'(e_rule));
        if (e_load) begin
            chk("row_select",    32'(bif.row_select),    32'(e_row));
            chk("r_val",         32'(bif.r_val),         32'(e_val));
            chk("nw_row_select", 32'(bif_nw.row_select), 32'(e_row));
        end
    endtask

    // One clock: check this cycle's outputs, advance the model, then clear pulses
    task automatic cycle();
        bit ack_seen;
        @(negedge clk);
        check_outputs();
        ack_seen = hif.host_ack;
        model_step();
        @(posedge clk);
        #1;
        step = 1'b0; clr = 1'b0; rule_ld = 1'b0;
        if (ack_seen) host_req = 1'b0;
    endtask

    task automatic run_n(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic chk_reset_values(input string pfx);
        chk({pfx, "_load_r"},     32'(bif.load_r),     32'd0);
        chk({pfx, "_row_select"}, 32'(bif.row_select), 32'd0);
        chk({pfx, "_r_val"},      32'(bif.r_val),      32'd0);
        chk({pfx, "_host_ack"},   32'(hif.host_ack),   32'd0);
        chk({pfx, "_cur_rule"},   32'(cur_rule),       32'd0);
        chk({pfx, "_head"},       32'(head),           32'd0);
        chk({pfx, "_gen_count"},  32'(gen_count),      32'd0);
        chk({pfx, "_busy"},       32'(busy),           32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("rst");
        model_reset();
        reset_n = 1'b1;

        // Seed 0x10 under rule 90, two generations
        clr = 1'b1; seed_val = 8'h10; rule_ld = 1'b1; rule_in = 8'h5A;
        cycle(); run_n(11);
        step = 1'b1; cycle(); run_n(3);
        chk("r90_row1", 32'(board[1]), 32'h28);
        chk("r90_head1", 32'(head), 32'd1);
        chk("r90_gen1", 32'(gen_count), 32'd1);
        step = 1'b1; cycle(); run_n(3);
        chk("r90_row2", 32'(board[2]), 32'h44);
        chk("r90_head2", 32'(head), 32'd2);

        // Edge behaviour: toroidal vs zero-padded neighbours
        clr = 1'b1; seed_val = 8'h01;
        cycle(); run_n(11);
        step = 1'b1; cycle(); run_n(3);
        chk("wrap1_row1", 32'(board[1]), 32'h82);
        chk("wrap0_row1", 32'(board_nw[1]), 32'h02);

        // Free run with tick every cycle for 40 cycles
        clr = 1'b1; cycle(); run_n(11);
        tick = 1'b1; run = 1'b1;
        run_n(40);
        tick = 1'b0; run = 1'b0;
        chk("run40_gen", 32'(gen_count), 32'd13);
        chk("run40_head", 32'(head), 32'd5);
        run_n(5);
        chk("run40_tail_gen", 32'(gen_count), 32'd14);

        // Tie with last grant GEN: host goes first
        host_req = 1'b1; host_row = 3'd3; host_data = 8'hA5; step = 1'b1;
        cycle();
        chk("tie_g_ack", 32'(hif.host_ack), 32'd1);
        chk("tie_g_row", 32'(bif.row_select), 32'd3);
        run_n(6);
        chk("tie_g_board3", 32'(board[3]), 32'hA5);
        chk("tie_g_gen", 32'(gen_count), 32'd15);

        // Tie with last grant HOST: generation goes first
        host_req = 1'b1; host_row = 3'd6; host_data = 8'h3C;
        run_n(4);
        host_req = 1'b1; host_row = 3'd2; host_data = 8'h77; step = 1'b1;
        cycle();
        chk("tie_h_ack_t1", 32'(hif.host_ack), 32'd0);
        chk("tie_h_busy_t1", 32'(busy), 32'd1);
        cycle();
        chk("tie_h_ack_t2", 32'(hif.host_ack), 32'd0);
        chk("tie_h_load_t2", 32'(bif.load_r), 32'd1);
        cycle(); cycle();
        chk("tie_h_ack_t4", 32'(hif.host_ack), 32'd1);
        run_n(3);
        chk("tie_h_gen", 32'(gen_count), 32'd16);

        // clr one cycle after step under rule 30
        rule_ld = 1'b1; rule_in = 8'd30; cycle();
        step = 1'b1; cycle();
        clr = 1'b1; seed_val = 8'h81; cycle();
        run_n(14);
        chk("clrmid_gen", 32'(gen_count), 32'd0);
        chk("clrmid_head", 32'(head), 32'd0);
        chk("clrmid_row0", 32'(board[0]), 32'h81);

        // Asynchronous reset while CLEAR is writing row 4
        clr = 1'b1; cycle(); run_n(4);
        chk("clr_row4_load", 32'(bif.load_r), 32'd1);
        chk("clr_row4_sel", 32'(bif.row_select), 32'd4);
        reset_n = 1'b0;
        #1;
        chk_reset_values("arst");
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Randomised traffic
        for (int k = 0; k < 600; k++) begin
            tick     = 1'($urandom_range(0, 1));
            run      = ($urandom_range(0, 3) != 0);
            step     = ($urandom_range(0, 7) == 0);
            clr      = ($urandom_range(0, 59) == 0);
            rule_ld  = ($urandom_range(0, 9) == 0);
            rule_in  = 8'($urandom);
            seed_val = 8'($urandom);
            if (!host_req && $urandom_range(0, 5) == 0) begin
                host_req  = 1'b1;
                host_row  = 3'($urandom);
                host_data = 8'($urandom);
            end
            cycle();
        end
        tick = 1'b0; run = 1'b0;
        run_n(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
